// File: rtl/shifter_pkg.sv
// Shared types and shifter_operand field positions for the Val2 operand unit.
// Build option SHIFTER_RRX_EN adds the RRX flag to the decoded S1 record.
package shifter_pkg;

    localparam int unsigned OP_W          = 12;
    localparam int unsigned AMT_W         = 8;
    localparam int unsigned ROT_MSB       = 11;
    localparam int unsigned ROT_LSB       = 8;
    localparam int unsigned IMM8_MSB      = 7;
    localparam int unsigned IMM8_LSB      = 0;
    localparam int unsigned SHAMT_MSB     = 11;
    localparam int unsigned SHAMT_LSB     = 7;
    localparam int unsigned TYPE_MSB      = 6;
    localparam int unsigned TYPE_LSB      = 5;
    localparam int unsigned REG_SHIFT_BIT = 4;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        MODE_IMM       = 2'b00,
        MODE_SHIFT_IMM = 2'b01,
        MODE_SHIFT_REG = 2'b10
    } mode_e;

    typedef struct packed {
        mode_e             mode;
        shift_type_e       stype;
        logic [AMT_W-1:0]  amt;
`ifdef SHIFTER_RRX_EN
        logic              rrx;
`endif
    } s1_dec_t;

endpackage

// File: rtl/shifter_operand_unit_if.sv
// Upstream and downstream handshake/payload bundle for shifter_operand_unit.
interface shifter_operand_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_imm;
    logic [11:0]       in_shift_op;
    logic [DATA_W-1:0] in_rm;
    logic [DATA_W-1:0] in_rs;
    logic              in_carry;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_val2;
    logic              out_carry;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_imm, in_shift_op, in_rm, in_rs, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_val2, out_carry, out_tag
    );

    modport slave (
        input  in_valid, in_imm, in_shift_op, in_rm, in_rs, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_val2, out_carry, out_tag
    );
endinterface

// File: rtl/shifter_core.sv
// Combinational S2 datapath: shift/rotate of the staged operand plus carry-out.
// With SHIFTER_RRX_EN defined the RRX path (carry into the MSB) is present.
module shifter_core
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  mode_e             mode,
    input  shift_type_e       stype,
    input  logic [AMT_W-1:0]  amt,
`ifdef SHIFTER_RRX_EN
    input  logic              rrx,
`endif
    input  logic [DATA_W-1:0] rm,
    input  logic              cin,
    output logic [DATA_W-1:0] val2_c,
    output logic              carry_c
);
    localparam int unsigned     LOG_W    = $clog2(DATA_W);
    localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(DATA_W);

    logic [LOG_W-1:0]  sh;
    logic [DATA_W:0]   lsl_ext;
    logic [DATA_W:0]   lsr_ext;
    logic [DATA_W:0]   asr_ext;
    logic [DATA_W-1:0] rot_val;

    // One extra bit on the shifted-out side captures the last bit shifted out.
    assign sh      = amt[LOG_W-1:0];
    assign lsl_ext = {1'b0, rm} << sh;
    assign lsr_ext = {rm, 1'b0} >> sh;
    assign asr_ext = (DATA_W+1)'($signed({rm, 1'b0}) >>> sh);
    assign rot_val = DATA_W'({rm, rm} >> sh);

    always_comb begin
        val2_c  = rm;
        carry_c = cin;
        if (mode == MODE_IMM) begin
            val2_c  = rot_val;
            carry_c = (amt == '0) ? cin : rot_val[DATA_W-1];
        end
`ifdef SHIFTER_RRX_EN
        else if (rrx) begin
            val2_c  = {cin, rm[DATA_W-1:1]};
            carry_c = rm[0];
        end
`endif
        else if (amt != '0) begin
            case (stype)
                SH_LSL: begin
                    if (amt < AMT_FULL) begin
                        val2_c  = lsl_ext[DATA_W-1:0];
                        carry_c = lsl_ext[DATA_W];
                    end else begin
                        val2_c  = '0;
                        carry_c = (amt == AMT_FULL) ? rm[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (amt < AMT_FULL) begin
                        val2_c  = lsr_ext[DATA_W:1];
                        carry_c = lsr_ext[0];
                    end else begin
                        val2_c  = '0;
                        carry_c = (amt == AMT_FULL) ? rm[DATA_W-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (amt < AMT_FULL) begin
                        val2_c  = asr_ext[DATA_W:1];
                        carry_c = asr_ext[0];
                    end else begin
                        val2_c  = {DATA_W{rm[DATA_W-1]}};
                        carry_c = rm[DATA_W-1];
                    end
                end
                // Multiples of DATA_W leave rm unrotated, so rot_val[MSB] is rm[MSB].
                default: begin
                    val2_c  = rot_val;
                    carry_c = rot_val[DATA_W-1];
                end
            endcase
        end
    end
endmodule

// File: rtl/shifter_operand_unit.sv
// Two-stage Val2 generator: S1 decodes the shifter_operand, S2 shifts and registers.
// SHIFTER_RRX_EN selects RRX for immediate ROR #0; otherwise it acts as LSL #0.
module shifter_operand_unit
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input logic              clk,
    input logic              rst_n,
    shifter_operand_unit_if.slave bus
);
    logic              s1_valid;
    s1_dec_t           s1_dec;
    logic [DATA_W-1:0] s1_opnd;
    logic              s1_cin;
    logic [TAG_W-1:0]  s1_tag;

    logic              s1_en;
    logic              s2_en;
    s1_dec_t           dec_c;
    logic [DATA_W-1:0] opnd_c;
    logic [DATA_W-1:0] val2_c;
    logic              carry_c;

    generate
        if (DATA_W > AMT_W) begin : g_rs_hi
            logic unused_rs_hi;
            assign unused_rs_hi = ^bus.in_rs[DATA_W-1:AMT_W];
        end
    endgenerate

    assign s2_en       = !bus.out_valid || bus.out_ready;
    assign s1_en       = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    // Decode mode, type and effective amount; immediates travel in the operand slot.
    always_comb begin
        dec_c       = '0;
        opnd_c      = bus.in_rm;
        dec_c.stype = shift_type_e'(bus.in_shift_op[TYPE_MSB:TYPE_LSB]);
        if (bus.in_imm) begin
            dec_c.mode = MODE_IMM;
            dec_c.amt  = AMT_W'({bus.in_shift_op[ROT_MSB:ROT_LSB], 1'b0}) & AMT_W'(DATA_W - 1);
            opnd_c     = DATA_W'(bus.in_shift_op[IMM8_MSB:IMM8_LSB]);
        end else if (bus.in_shift_op[REG_SHIFT_BIT]) begin
            dec_c.mode = MODE_SHIFT_REG;
            dec_c.amt  = bus.in_rs[AMT_W-1:0];
        end else begin
            dec_c.mode = MODE_SHIFT_IMM;
            dec_c.amt  = AMT_W'(bus.in_shift_op[SHAMT_MSB:SHAMT_LSB]);
            if (bus.in_shift_op[SHAMT_MSB:SHAMT_LSB] == '0) begin
                if (dec_c.stype == SH_LSR || dec_c.stype == SH_ASR) begin
                    dec_c.amt = AMT_W'(DATA_W);
                end
`ifdef SHIFTER_RRX_EN
                else if (dec_c.stype == SH_ROR) begin
                    dec_c.rrx = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dec   <= '0;
            s1_opnd  <= '0;
            s1_cin   <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_dec  <= dec_c;
                s1_opnd <= opnd_c;
                s1_cin  <= bus.in_carry;
                s1_tag  <= bus.in_tag;
            end
        end
    end

    shifter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .mode    (s1_dec.mode),
        .stype   (s1_dec.stype),
        .amt     (s1_dec.amt),
`ifdef SHIFTER_RRX_EN
        .rrx     (s1_dec.rrx),
`endif
        .rm      (s1_opnd),
        .cin     (s1_cin),
        .val2_c  (val2_c),
        .carry_c (carry_c)
    );

    // Output stage holds its payload while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_val2  <= '0;
            bus.out_carry <= 1'b0;
            bus.out_tag   <= '0;
        end else if (s2_en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_val2  <= val2_c;
                bus.out_carry <= carry_c;
                bus.out_tag   <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_shifter_operand_unit.sv
// Self-checking bench for shifter_operand_unit: directed encodings plus randomized
// traffic with random backpressure against an arithmetic reference model.
module tb_shifter_operand_unit;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shifter_operand_unit_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    shifter_operand_unit #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] val;
        logic        carry;
        logic [3:0]  tag;
    } exp_t;

    // Reference model: {carry, val2} straight from the operand rules, 32-bit operand.
    function automatic logic [32:0] model(input logic imm, input logic [11:0] op,
                                          input logic [31:0] rm, input logic [31:0] rs,
                                          input logic cin);
        int n;
        int r;
        int typ;
        logic [31:0] res;
        logic c;
        longint unsigned x;
        typ = int'(op[6:5]);
        if (imm) begin
            n   = 2 * int'(op[11:8]);
            x   = 64'(op[7:0]);
            res = 32'((x >> n) | (x << (32 - n)));
            c   = (n == 0) ? cin : res[31];
            return {c, res};
        end
        n = op[4] ? int'(rs[7:0]) : int'(op[11:7]);
`ifdef SHIFTER_RRX_EN
        if (!op[4] && n == 0 && typ == 3) return {rm[0], cin, rm[31:1]};
`endif
        if (!op[4] && n == 0 && (typ == 1 || typ == 2)) n = 32;
        if (n == 0) return {cin, rm};
        res = rm;
        c   = cin;
        case (typ)
            0: begin
                if (n >= 32) res = 32'h0; else res = rm << n;
                if (n > 32) c = 1'b0; else c = rm[32 - n];
            end
            1: begin
                if (n >= 32) res = 32'h0; else res = rm >> n;
                if (n > 32) c = 1'b0; else c = rm[n - 1];
            end
            2: begin
                if (n >= 32) begin
                    res = {32{rm[31]}};
                    c   = rm[31];
                end else begin
                    res = 32'($signed(rm) >>> n);
                    c   = rm[n - 1];
                end
            end
            default: begin
                r = n % 32;
                if (r == 0) res = rm; else res = (rm >> r) | (rm << (32 - r));
                c = res[31];
            end
        endcase
        return {c, res};
    endfunction

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_imm      = 1'b0;
        bus.in_shift_op = '0;
        bus.in_rm       = '0;
        bus.in_rs       = '0;
        bus.in_carry    = 1'b0;
        bus.in_tag      = '0;
    endtask

    // Issues one operation from a negedge and returns its result; ok=0 on timeout.
    task automatic run_one(input logic imm, input logic [11:0] op, input logic [31:0] rm,
                           input logic [31:0] rs, input logic cin, input logic [3:0] tag,
                           output logic [31:0] v, output logic c, output logic [3:0] t,
                           output bit ok);
        int guard;
        ok = 1'b1; v = '0; c = 1'b0; t = '0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_imm = imm; bus.in_shift_op = op;
        bus.in_rm = rm; bus.in_rs = rs; bus.in_carry = cin; bus.in_tag = tag;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin @(negedge clk); #1; guard++; end
        if (!bus.in_ready) ok = 1'b0;
        @(negedge clk);
        drive_idle();
        #1;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin @(negedge clk); #1; guard++; end
        if (!bus.out_valid) ok = 1'b0;
        v = bus.out_val2; c = bus.out_carry; t = bus.out_tag;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive_idle();
        bus.in_valid = 1'b1; bus.in_imm = 1'b1; bus.in_shift_op = 12'h0AB;
        bus.in_carry = 1'b0; bus.in_tag = 4'd5;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.out_val2 !== 32'h0 || bus.out_carry !== 1'b0 || bus.out_tag !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got valid=%b val2=%h carry=%b tag=%h, expected all zero",
                         i, bus.out_valid, bus.out_val2, bus.out_carry, bus.out_tag);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_latency1: out_valid got %b expected 0", bus.out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_val2 !== 32'h000000AB || bus.out_carry !== 1'b0 || bus.out_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL reset_first_result: got valid=%b val2=%h carry=%b tag=%h expected 1/000000ab/0/5",
                     bus.out_valid, bus.out_val2, bus.out_carry, bus.out_tag);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_dup: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_imm();
        logic [31:0] v; logic c; logic [3:0] t; bit ok;
        run_one(1'b1, 12'h4FF, $urandom, $urandom, 1'b0, 4'd1, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'hFF000000 || c !== 1'b1 || t !== 4'd1) begin
            n_fail++; $display("FAIL imm_4ff: ok=%b got %h/%b/%h expected ff000000/1/1", ok, v, c, t);
        end
        run_one(1'b1, 12'h0AB, $urandom, $urandom, 1'b0, 4'd2, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'h000000AB || c !== 1'b0 || t !== 4'd2) begin
            n_fail++; $display("FAIL imm_0ab: ok=%b got %h/%b/%h expected 000000ab/0/2", ok, v, c, t);
        end
        run_one(1'b1, 12'h0AB, $urandom, $urandom, 1'b1, 4'd3, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'h000000AB || c !== 1'b1) begin
            n_fail++; $display("FAIL imm_rot0_carry: ok=%b got %h/%b expected 000000ab/1", ok, v, c);
        end
    endtask

    task automatic test_lsl_reg();
        logic [31:0] v; logic c; logic [3:0] t; bit ok;
        run_one(1'b0, 12'h010, 32'h80000001, 32'd32, 1'b0, 4'd4, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'h0 || c !== 1'b1) begin
            n_fail++; $display("FAIL lsl_reg_32: ok=%b got %h/%b expected 00000000/1", ok, v, c);
        end
        run_one(1'b0, 12'h010, 32'h80000001, 32'd33, 1'b1, 4'd5, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'h0 || c !== 1'b0) begin
            n_fail++; $display("FAIL lsl_reg_33: ok=%b got %h/%b expected 00000000/0", ok, v, c);
        end
        for (int k = 0; k < 2; k++) begin
            run_one(1'b0, 12'h010, 32'h80000001, 32'h100, 1'(k), 4'd6, v, c, t, ok);
            n_checks++;
            if (!ok || v !== 32'h80000001 || c !== 1'(k)) begin
                n_fail++; $display("FAIL lsl_reg_amt0[%0d]: ok=%b got %h/%b expected 80000001/%0d", k, ok, v, c, k);
            end
        end
    endtask

    task automatic test_imm_zero();
        logic [31:0] v; logic c; logic [3:0] t; bit ok;
        run_one(1'b0, 12'h040, 32'h80000000, 32'h0, 1'b0, 4'd7, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'hFFFFFFFF || c !== 1'b1) begin
            n_fail++; $display("FAIL asr_imm0: ok=%b got %h/%b expected ffffffff/1", ok, v, c);
        end
        run_one(1'b0, 12'h020, 32'h80000000, 32'h0, 1'b0, 4'd8, v, c, t, ok);
        n_checks++;
        if (!ok || v !== 32'h0 || c !== 1'b1) begin
            n_fail++; $display("FAIL lsr_imm0: ok=%b got %h/%b expected 00000000/1", ok, v, c);
        end
        run_one(1'b0, 12'h060, 32'h00000001, 32'h0, 1'b1, 4'd9, v, c, t, ok);
`ifdef SHIFTER_RRX_EN
        n_checks++;
        if (!ok || v !== 32'h80000000 || c !== 1'b1) begin
            n_fail++; $display("FAIL rrx: ok=%b got %h/%b expected 80000000/1", ok, v, c);
        end
`else
        n_checks++;
        if (!ok || v !== 32'h00000001 || c !== 1'b1) begin
            n_fail++; $display("FAIL ror_imm0: ok=%b got %h/%b expected 00000001/1", ok, v, c);
        end
`endif
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [32:0] m;
        q.delete();
        for (int cyc = 0; cyc < 700; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (cyc < 600 && $urandom_range(0, 3) != 0) begin
                bus.in_valid    = 1'b1;
                bus.in_imm      = ($urandom_range(0, 3) == 0);
                bus.in_shift_op = 12'($urandom);
                bus.in_rm       = $urandom;
                bus.in_rs       = $urandom;
                if ($urandom_range(0, 1) == 1) bus.in_rs[7:0] = 8'($urandom_range(0, 66));
                bus.in_carry    = 1'($urandom);
                bus.in_tag      = 4'($urandom);
            end else begin
                drive_idle();
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: cycle %0d got unexpected result %h", cyc, bus.out_val2);
                end else begin
                    e = q.pop_front();
                    if (bus.out_val2 !== e.val || bus.out_carry !== e.carry || bus.out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL rand_result: cycle %0d got %h/%b/%h expected %h/%b/%h",
                                 cyc, bus.out_val2, bus.out_carry, bus.out_tag, e.val, e.carry, e.tag);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.in_imm, bus.in_shift_op, bus.in_rm, bus.in_rs, bus.in_carry);
                q.push_back('{m[31:0], m[32], bus.in_tag});
            end
            @(negedge clk);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain: got %0d results outstanding expected 0", q.size());
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rms[4];
        logic [32:0] em[4];
        int acc = 0;
        int got = 0;
        for (int i = 0; i < 4; i++) begin
            rms[i] = $urandom;
            em[i]  = model(1'b0, 12'h030, rms[i], 32'(i + 1), 1'b0);
        end
        bus.out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.in_valid = 1'b1; bus.in_imm = 1'b0; bus.in_shift_op = 12'h030;
            bus.in_rm = rms[acc]; bus.in_rs = 32'(acc + 1); bus.in_carry = 1'b0;
            bus.in_tag = 4'(acc + 1);
            #1;
            if (cyc >= 2) begin
                n_checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_val2 !== em[0][31:0] ||
                    bus.out_carry !== em[0][32] || bus.out_tag !== 4'd1) begin
                    n_fail++;
                    $display("FAIL b2b_stall[%0d]: got ready=%b valid=%b %h/%b/%h expected 0/1 %h/%b/1",
                             cyc, bus.in_ready, bus.out_valid, bus.out_val2, bus.out_carry, bus.out_tag,
                             em[0][31:0], em[0][32]);
                end
            end
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d accepts expected 2", acc);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (acc < 4) begin
                bus.in_valid = 1'b1; bus.in_rm = rms[acc];
                bus.in_rs = 32'(acc + 1); bus.in_tag = 4'(acc + 1);
            end else begin
                drive_idle();
            end
            #1;
            if (bus.out_valid) begin
                n_checks++;
                if (bus.out_tag !== 4'(got + 1) || bus.out_val2 !== em[got][31:0] || bus.out_carry !== em[got][32]) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got %h/%b/%h expected %h/%b/%h", got,
                             bus.out_val2, bus.out_carry, bus.out_tag, em[got][31:0], em[got][32], 4'(got + 1));
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        drive_idle();
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d results expected 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_imm();
        test_lsl_reg();
        test_imm_zero();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shifter_operand_unit.md
# shifter_operand_unit

Pipelined, parametrised second-operand (Val2) generator for the EXE stage. It produces the shifted or rotated operand and the shifter carry-out for data-processing instructions. It supports rotated immediates, immediate-amount shifts including the LSR/ASR #32 and RRX encodings, and register-specified shifts by Rs[7:0]. Registered valid/ready handshakes on both sides let it sit between ID/EXE and the ALU under pipeline stalls.

## Interface
Parameters:
- DATA_W, 32, operand width; power of two, 8..64
- TAG_W, 4, width of the sideband tag carried with each operation

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept this cycle
- in_imm  in  1  I bit: 1 selects the rotated-immediate form
- in_shift_op  in  12  instruction shifter_operand field [11:0]
- in_rm  in  DATA_W  Rm value
- in_rs  in  DATA_W  Rs value; only [7:0] used
- in_carry  in  1  current CPSR C flag
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_val2  out  DATA_W  shifted operand
- out_carry  out  1  shifter carry-out
- out_tag  out  TAG_W  tag of the result

## Operation
- Transfer occurs on valid && ready at each side. Results are delivered in order, with no drop and no duplication.
- Stage S1 registers decoded fields:
  - mode: IMM, SHIFT_IMM, or SHIFT_REG, where SHIFT_REG means in_imm=0 and shift_op[4]=1.
  - type: shift_op[6:5], where 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROR.
  - amt: 8-bit effective amount.
- Effective amount in S1:
  - IMM: rot = 2 × shift_op[11:8], taken mod DATA_W.
  - SHIFT_IMM: shift_op[11:7]. An amount of 0 with LSR or ASR means 32. An amount of 0 with ROR means RRX.
  - SHIFT_REG: in_rs[7:0].
- Stage S2 performs the shift and carry computation and registers the outputs.
- IMM: val2 = ROR(zero-extended imm8, rot). carry = in_carry when rot = 0, otherwise val2[DATA_W-1].
- Amount 0, except the encodings above: val2 = Rm, carry = in_carry.
- LSL n:
  - n < DATA_W: carry = Rm[DATA_W-n].
  - n = DATA_W: val2 = 0, carry = Rm[0].
  - n > DATA_W: val2 = 0, carry = 0.
- LSR n:
  - n < DATA_W: carry = Rm[n-1].
  - n = DATA_W: val2 = 0, carry = Rm[DATA_W-1].
  - n > DATA_W: val2 = 0, carry = 0.
- ASR n:
  - n < DATA_W: carry = Rm[n-1].
  - n ≥ DATA_W: val2 = all copies of the sign bit, carry = sign bit.
- ROR n, with n ≠ 0 and n mod DATA_W = 0: val2 = Rm, carry = Rm[DATA_W-1].
- ROR n, other nonzero n: rotate by n mod DATA_W, carry = val2[DATA_W-1].
- RRX: val2 = {in_carry, Rm[DATA_W-1:1]}, carry = Rm[0].
- For DATA_W ≠ 32, the "32" in the LSR/ASR #0 encodings reads as DATA_W.

## Timing
- Latency is 2 cycles from input acceptance to out_valid, assuming no backpressure. Throughput is 1 operation per cycle.
- Handshake enables:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- in_ready is combinational from out_ready. There is no path from in_valid to in_ready.
- When out_valid=1 and out_ready=0, out_val2, out_carry and out_tag hold stable.
- Reset (rst_n=0 at an edge): s1_valid = 0, s2_valid = 0, out_valid = 0, out_val2 = 0, out_carry = 0, out_tag = 0. Reset mid-operation discards in-flight operations.
- Simultaneous output pop and input push with both stages full: all stages advance and nothing is lost.

## Configuration
- Macro: SHIFTER_RRX_EN.
- Defined: ROR #0 in the immediate-shift form performs RRX as specified above.
- Undefined: ROR #0 behaves like LSL #0, giving val2 = Rm and carry = in_carry. The in_carry path into the S2 datapath MSB is removed.

## Structure
- shifter_pkg contains:
  - shift_type_e (LSL, LSR, ASR, ROR)
  - mode_e (IMM, SHIFT_IMM, SHIFT_REG)
  - field position constants for shift_op
  - the decoded S1 struct type
- Sub-module shifter_core holds the purely combinational S2 shift and carry logic, parametrised by DATA_W. The top level holds decode, the pipeline registers and the handshake.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1. Required: out_valid=0 and outputs 0 throughout; the first result appears 2 cycles after release.
- Rotated immediate: in_imm=1, shift_op=0x4FF. Required: out_val2=0xFF000000, out_carry=1. With shift_op=0x0AB and in_carry=0: 0x000000AB, carry 0.
- Register LSL boundaries:
  - Rm=0x80000001, shift_op=0x010, Rs=32 → val2 0, carry 1.
  - Rs=33 → val2 0, carry 0.
  - Rs=0x100 (amt 0) → val2 0x80000001, carry = in_carry.
- Immediate #0 encodings:
  - ASR #0 (shift_op=0x040) with Rm=0x80000000 → 0xFFFFFFFF, carry 1.
  - LSR #0 (0x020) → 0, carry 1.
  - RRX (0x060) with Rm=1, in_carry=1 → 0x80000000, carry 1 when SHIFTER_RRX_EN is defined; 0x00000001, carry 1 when it is not.
- Backpressure: push tags 1..4 back-to-back with out_ready=0 for 4 cycles. Required: in_ready falls after 2 accepts. After out_ready=1, tags come out 1,2,3,4 in order, with out_val2 stable while stalled.
